pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined MIPS core; it replaces the separate load-use stall and forwarding logic.
- Keeps a scoreboard shift register of in-flight destination registers, DEPTH stages deep, starting at EX.
- Each cycle, returns per-operand forward-source selects for the instruction in ID, plus stall and flush controls.
- Adds configurable load latency, a multi-cycle-op busy counter, branch/jump squash, and a saturating stall-cycle counter.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 47 ++++
 rtl/pipe_hazard_ctrl_src_match.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//
// Shared types and helpers for the pipeline hazard / forwarding controller.
//
// Contents:
//   SB_AW_MAX    - storage width of a scoreboard destination address. Register
//                  addresses narrower than this are zero-extended on entry, so
//                  the package does not depend on the AW parameter of the top.
//   FWD_RF       - forward-select value meaning "read the register file".
//   sb_entry_t   - one scoreboard slot {v, wr, wa, ld}.
//   SB_BUBBLE    - an empty slot (v = 0).
//   fwd_sel      - forward-select encoding for a given stage index.
//   stage_ready  - whether a result sitting at a stage can be forwarded yet.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int SB_AW_MAX = 16;
    localparam int FWD_RF    = 0;

    typedef struct packed {
        logic                 v;
        logic                 wr;
        logic [SB_AW_MAX-1:0] wa;
        logic                 ld;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Stage k is selected as k+1 so that 0 stays free for the register file.
    function automatic int fwd_sel(input int stage);
        return stage + FWD_RF + 1;
    endfunction

    // Loads produce data later than ALU ops, so each class has its own
    // earliest stage from which the value can be bypassed.
    function automatic logic stage_ready(input logic ld,
                                         input int   stage,
                                         input int   alu_rdy,
                                         input int   load_rdy);
        if (ld) begin
            return (stage >= load_rdy);
        end
        return (stage >= alu_rdy);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_src_match.sv
// ---------------------------------------------------------------------------
// pipe_src_match
//
// Per-operand priority search over the scoreboard. Finds the youngest
// in-flight instruction that writes the source register and decides whether
// its result can be forwarded now or the consumer must wait.
//
// Ports:
//   src      in   AW          source register address of the ID instruction
//   use_src  in   1           ID instruction actually reads this operand
//   sb       in   DEPTH slots scoreboard, index 0 = EX (youngest)
//   fwd      out  SELW        0 = register file, k+1 = stage k
//   hazard   out  1           youngest producer exists but is not ready
// ---------------------------------------------------------------------------
module pipe_src_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 0,
    parameter int LOAD_RDY = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic [AW-1:0]              src,
    input  logic                       use_src,
    input  sb_entry_t [DEPTH-1:0]      sb,
    output logic [SELW-1:0]            fwd,
    output logic                       hazard
);

    logic [SB_AW_MAX-1:0] src_ext;
    logic                 src_live;

    // Register 0 is hard-wired to zero, so it never has a producer to wait on
    // even if some in-flight instruction names it as destination.
    assign src_ext  = SB_AW_MAX'(src);
    assign src_live = use_src && (src != '0);

    // The first hit from the EX end wins outright. An older, already-ready
    // copy must not be used when a younger write to the same register is
    // still in flight, hence the found flag stops the search at the first
    // match whether or not it is ready.
    always_comb begin
        logic found;
        found  = 1'b0;
        fwd    = SELW'(FWD_RF);
        hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && src_live && sb[k].v && sb[k].wr &&
                (sb[k].wa == src_ext)) begin
                found = 1'b1;
                if (stage_ready(sb[k].ld, k, ALU_RDY, LOAD_RDY)) begin
                    fwd = SELW'(fwd_sel(k));
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for the pipelined MIPS core. Tracks the
// destination registers of instructions past ID in a shift-register
// scoreboard, selects bypass sources for the ID operands, and produces stall
// and flush controls. Also owns the multi-cycle-unit busy counter and a
// saturating count of stall cycles.
//
// Parameters:
//   AW        register address width (must not exceed SB_AW_MAX)
//   DEPTH     tracked stages after ID (0 = EX, 1 = MEM, 2 = WB by default)
//   ALU_RDY   earliest stage index a non-load result may be forwarded from
//   LOAD_RDY  earliest stage index load data may be forwarded from
//   SELW      width of the forward selects
//
// Ports:
//   clk        in   1     clock, rising edge
//   reset      in   1     asynchronous reset, active low
//   id_valid   in   1     ID holds a real instruction
//   id_rs      in   AW    ID source register 1
//   id_rt      in   AW    ID source register 2
//   id_use_rs  in   1     ID instruction reads rs
//   id_use_rt  in   1     ID instruction reads rt
//   id_wr      in   1     ID instruction writes a register
//   id_wa      in   AW    ID destination register
//   id_ld      in   1     ID instruction is a load
//   id_mc      in   1     ID instruction is a multi-cycle op
//   mc_cycles  in   8     busy length of that multi-cycle op
//   redirect   in   1     branch taken / jump resolved this cycle
//   stall      out  1     hold PC and IF/ID, bubble into ID/EX
//   flush      out  1     squash IF/ID contents
//   fwd_rs     out  SELW  0 = register file, k+1 = stage k
//   fwd_rt     out  SELW  same encoding for rt
//   mc_busy    out  1     multi-cycle unit occupied
//   stall_cnt  out  16    saturating count of stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 0,
    parameter int LOAD_RDY = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr,
    input  logic [AW-1:0]   id_wa,
    input  logic            id_ld,
    input  logic            id_mc,
    input  logic [7:0]      mc_cycles,
    input  logic            redirect,
    output logic            stall,
    output logic            flush,
    output logic [SELW-1:0] fwd_rs,
    output logic [SELW-1:0] fwd_rt,
    output logic            mc_busy,
    output logic [15:0]     stall_cnt
);

    sb_entry_t [DEPTH-1:0] sb;
    sb_entry_t             id_entry;
    logic [7:0]            mc_count;
    logic                  haz_rs;
    logic                  haz_rt;
    logic                  accept;

    pipe_src_match #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .ALU_RDY  (ALU_RDY),
        .LOAD_RDY (LOAD_RDY),
        .SELW     (SELW)
    ) u_match_rs (
        .src     (id_rs),
        .use_src (id_use_rs),
        .sb      (sb),
        .fwd     (fwd_rs),
        .hazard  (haz_rs)
    );

    pipe_src_match #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .ALU_RDY  (ALU_RDY),
        .LOAD_RDY (LOAD_RDY),
        .SELW     (SELW)
    ) u_match_rt (
        .src     (id_rt),
        .use_src (id_use_rt),
        .sb      (sb),
        .fwd     (fwd_rt),
        .hazard  (haz_rt)
    );

    // A redirect squashes the ID instruction anyway, so stalling it would
    // only delay the fetch of the branch target.
    assign mc_busy = (mc_count != 8'd0);
    assign stall   = id_valid && !redirect && (haz_rs || haz_rt || mc_busy);
    assign flush   = redirect;
    assign accept  = id_valid && !stall && !redirect;

    always_comb begin
        id_entry    = SB_BUBBLE;
        id_entry.v  = 1'b1;
        id_entry.wr = id_wr;
        id_entry.wa = SB_AW_MAX'(id_wa);
        id_entry.ld = id_ld;
    end

    // Scoreboard ages by one stage every cycle regardless of stall: a stall
    // holds ID, but the instructions ahead of it keep moving, and the slot
    // behind them is filled with a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[0] <= accept ? id_entry : SB_BUBBLE;
        end
    end

    // Busy counter only starts on an instruction that actually issues, so a
    // squashed or stalled multi-cycle op does not occupy the unit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_count <= 8'd0;
        end else if (accept && id_mc) begin
            mc_count <= mc_cycles;
        end else if (mc_count != 8'd0) begin
            mc_count <= mc_count - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. A cycle-by-cycle vector table drives
// the default configuration; hand-written sequences cover asynchronous reset
// in the middle of a stall and a deeper configuration (DEPTH = 5,
// LOAD_RDY = 3) sharing the same inputs.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  rs;
        logic        use_rs;
        logic [4:0]  rt;
        logic        use_rt;
        logic        wr;
        logic [4:0]  wa;
        logic        ld;
        logic        mc;
        logic [7:0]  mcc;
        logic        rd;
        logic        e_stall;
        logic        e_flush;
        logic [1:0]  e_rs;
        logic [1:0]  e_rt;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_wr;
    logic [4:0]  id_wa;
    logic        id_ld;
    logic        id_mc;
    logic [7:0]  mc_cycles;
    logic        redirect;

    logic        stall;
    logic        flush;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic        mc_busy;
    logic [15:0] stall_cnt;

    logic        d2_stall;
    logic        d2_flush;
    logic [2:0]  d2_fwd_rs;
    logic [2:0]  d2_fwd_rt;
    logic        d2_mc_busy;
    logic [15:0] d2_stall_cnt;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    pipe_hazard_ctrl #(
        .AW(5), .DEPTH(3), .ALU_RDY(0), .LOAD_RDY(1)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wa(id_wa),
        .id_ld(id_ld), .id_mc(id_mc), .mc_cycles(mc_cycles),
        .redirect(redirect), .stall(stall), .flush(flush),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .mc_busy(mc_busy),
        .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(
        .AW(5), .DEPTH(5), .ALU_RDY(0), .LOAD_RDY(3)
    ) dut_deep (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wa(id_wa),
        .id_ld(id_ld), .id_mc(id_mc), .mc_cycles(mc_cycles),
        .redirect(redirect), .stall(d2_stall), .flush(d2_flush),
        .fwd_rs(d2_fwd_rs), .fwd_rt(d2_fwd_rt), .mc_busy(d2_mc_busy),
        .stall_cnt(d2_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic valid,
                                logic [4:0] rs, logic urs,
                                logic [4:0] rt, logic urt,
                                logic wr, logic [4:0] wa, logic ld,
                                logic mc, logic [7:0] mcc, logic rd,
                                logic es, logic ef,
                                logic [1:0] ers, logic [1:0] ert,
                                logic eb, logic [15:0] ec);
        vec_t v;
        v.name = n;   v.valid = valid;
        v.rs = rs;    v.use_rs = urs;
        v.rt = rt;    v.use_rt = urt;
        v.wr = wr;    v.wa = wa;     v.ld = ld;
        v.mc = mc;    v.mcc = mcc;   v.rd = rd;
        v.e_stall = es; v.e_flush = ef;
        v.e_rs = ers;   v.e_rt = ert;
        v.e_busy = eb;  v.e_cnt = ec;
        return v;
    endfunction

    task automatic checkOne(input string nm, input logic [15:0] act,
                            input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_valid  = v.valid;
        id_rs     = v.rs;
        id_use_rs = v.use_rs;
        id_rt     = v.rt;
        id_use_rt = v.use_rt;
        id_wr     = v.wr;
        id_wa     = v.wa;
        id_ld     = v.ld;
        id_mc     = v.mc;
        mc_cycles = v.mcc;
        redirect  = v.rd;
    endtask

    task automatic checkOutput(input vec_t v);
        checkOne({v.name, ".stall"},     16'(stall),   16'(v.e_stall));
        checkOne({v.name, ".flush"},     16'(flush),   16'(v.e_flush));
        checkOne({v.name, ".fwd_rs"},    16'(fwd_rs),  16'(v.e_rs));
        checkOne({v.name, ".fwd_rt"},    16'(fwd_rt),  16'(v.e_rt));
        checkOne({v.name, ".mc_busy"},   16'(mc_busy), 16'(v.e_busy));
        checkOne({v.name, ".stall_cnt"}, stall_cnt,    v.e_cnt);
    endtask

    task automatic idle();
        applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        //            name       vld rs  urs rt  urt wr wa  ld mc mcc rd  st fl frs frt bsy cnt
        vecs.push_back(mk("lw_r8",   1, 1,  1, 0,  0, 1, 8,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lu_stl",  1, 8,  1, 8,  1, 1, 9,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lu_fwd",  1, 8,  1, 8,  1, 1, 9,  0, 0, 0, 0,  0, 0, 2, 2, 0, 1));
        vecs.push_back(mk("add_r3",  1, 1,  1, 2,  1, 1, 3,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sub_r4",  1, 3,  1, 5,  1, 1, 4,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("or_r6",   1, 3,  1, 9,  1, 1, 6,  0, 0, 0, 0,  0, 0, 2, 3, 0, 1));
        vecs.push_back(mk("addi_r7", 1, 0,  1, 0,  0, 1, 7,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ori_r7",  1, 7,  1, 0,  0, 1, 7,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("yng_win", 1, 7,  1, 0,  1, 1, 1,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1));
        vecs.push_back(mk("wr_r0",   1, 7,  1, 0,  0, 1, 0,  0, 0, 0, 0,  0, 0, 2, 0, 0, 1));
        vecs.push_back(mk("rd_r0",   1, 0,  1, 0,  1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("add_r5",  1, 0,  0, 0,  0, 1, 5,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lw_r5",   1, 0,  0, 0,  0, 1, 5,  1, 0, 0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("yng_nrd", 1, 5,  1, 0,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("yng_ld",  1, 5,  1, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 2, 0, 0, 2));
        vecs.push_back(mk("lw_r10",  1, 0,  0, 0,  0, 1, 10, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("rd_stl",  1, 10, 1, 0,  0, 0, 0,  0, 0, 0, 1,  0, 1, 0, 0, 0, 2));
        vecs.push_back(mk("rd_aft",  1, 10, 1, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 2, 0, 0, 2));
        vecs.push_back(mk("mc4",     1, 0,  0, 0,  0, 0, 0,  0, 1, 4, 0,  0, 0, 0, 0, 0, 2));
        vecs.push_back(mk("mc_w1",   1, 1,  1, 0,  0, 1, 11, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2));
        vecs.push_back(mk("mc_w2",   1, 1,  1, 0,  0, 1, 11, 0, 0, 0, 0,  1, 0, 0, 0, 1, 3));
        vecs.push_back(mk("mc_w3",   1, 1,  1, 0,  0, 1, 11, 0, 0, 0, 0,  1, 0, 0, 0, 1, 4));
        vecs.push_back(mk("mc_w4",   1, 1,  1, 0,  0, 1, 11, 0, 0, 0, 0,  1, 0, 0, 0, 1, 5));
        vecs.push_back(mk("mc_done", 1, 1,  1, 0,  0, 1, 11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 6));
        vecs.push_back(mk("mc0",     1, 0,  0, 0,  0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0, 6));
        vecs.push_back(mk("mc0_aft", 1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 6));
        vecs.push_back(mk("mc_rdr",  1, 0,  0, 0,  0, 0, 0,  0, 1, 3, 1,  0, 1, 0, 0, 0, 6));
        vecs.push_back(mk("mcr_aft", 1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 6));
        vecs.push_back(mk("mc2",     1, 0,  0, 0,  0, 0, 0,  0, 1, 2, 0,  0, 0, 0, 0, 0, 6));
        vecs.push_back(mk("bsy_rdr", 1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 1,  0, 1, 0, 0, 1, 6));
        vecs.push_back(mk("bsy_stl", 1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 1, 6));
        vecs.push_back(mk("bsy_end", 1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 7));

        // Reset state, with a live instruction presented in ID.
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(mk("rst", 1, 3, 1, 4, 1, 1, 3, 1, 1, 9, 0,
                         0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, 0, 0, 0, 0));
        idle();
        reset = 1'b1;

        // Main table: one vector per clock, inputs driven after the edge,
        // outputs sampled on the falling edge.
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i]);
        end

        // Asynchronous reset while both a load-use hazard and the
        // multi-cycle unit are holding the pipe.
        @(posedge clk);
        #1;
        applyStimulus(mk("mc_ld", 1, 0, 0, 0, 0, 1, 12, 1, 1, 5, 0,
                         0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        applyStimulus(mk("use12", 1, 12, 1, 12, 1, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOne("pre_rst.stall", 16'(stall), 16'd1);
        checkOne("pre_rst.busy",  16'(mc_busy), 16'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOne("async_rst.stall",  16'(stall),   16'd0);
        checkOne("async_rst.busy",   16'(mc_busy), 16'd0);
        checkOne("async_rst.fwd_rs", 16'(fwd_rs),  16'd0);
        checkOne("async_rst.fwd_rt", 16'(fwd_rt),  16'd0);
        checkOne("async_rst.flush",  16'(flush),   16'd0);
        checkOne("async_rst.cnt",    stall_cnt,    16'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;

        // Deep configuration: load data forwardable only from stage 3.
        @(posedge clk);
        #1;
        applyStimulus(mk("lw_r8", 1, 12, 1, 0, 0, 1, 8, 1, 0, 0, 0,
                         0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOne("post_rst.stall",  16'(stall),  16'd0);
        checkOne("post_rst.fwd_rs", 16'(fwd_rs), 16'd0);
        checkOne("deep_lw.stall",   16'(d2_stall), 16'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(mk("use8", 1, 8, 1, 8, 1, 1, 9, 0, 0, 0, 0,
                             0, 0, 0, 0, 0, 0));
            @(negedge clk);
            checkOne($sformatf("deep_stl%0d.stall", c), 16'(d2_stall), 16'd1);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOne("deep_fwd.stall",  16'(d2_stall),   16'd0);
        checkOne("deep_fwd.fwd_rs", 16'(d2_fwd_rs),  16'd4);
        checkOne("deep_fwd.fwd_rt", 16'(d2_fwd_rt),  16'd4);
        checkOne("deep_fwd.cnt",    d2_stall_cnt,    16'd3);
        checkOne("deep_fwd.busy",   16'(d2_mc_busy), 16'd0);
        checkOne("deep_fwd.flush",  16'(d2_flush),   16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
